// File: rtl/led_matrix_scanner.sv
// Scans four 8-bit column images onto an active-low 8x4 LED matrix, blanking before each column.
// The column images are snapshotted once per frame so that a frame never mixes old and new data.
module led_matrix_scanner #(
    parameter int unsigned DRIVE_CYCLES = 3000,
    parameter int unsigned BLANK_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] column_1,
    input  logic [7:0] column_2,
    input  logic [7:0] column_3,
    input  logic [7:0] column_4,
    output logic [7:0] led_rows,
    output logic [3:0] led_columns,
    output logic       frame_start
);

    localparam int unsigned PERIOD = BLANK_CYCLES + DRIVE_CYCLES;
    localparam int unsigned CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [31:0]   r_snap;

    logic [CW-1:0] w_cnt_nxt;
    logic [1:0]    w_idx_nxt;
    logic [31:0]   w_snap_nxt;
    logic          w_col_wrap;
    logic          w_frame_wrap;
    logic          w_drive_nxt;
    logic [7:0]    w_sel_nxt;
    logic [7:0]    w_rows_nxt;
    logic [3:0]    w_cols_nxt;
    logic [31:0]   w_inputs;

    assign w_inputs = {column_4, column_3, column_2, column_1};

    // Next scan position and snapshot. Outputs are decoded from these next values
    // so that the output flops always match the state the counter is about to hold.
    always_comb begin
        w_col_wrap   = (r_cnt == CW'(PERIOD - 1));
        w_frame_wrap = w_col_wrap && (r_idx == 2'd3);
        w_cnt_nxt    = r_cnt + CW'(1);
        w_idx_nxt    = r_idx;
        w_snap_nxt   = r_snap;
        if (reset) begin
            w_cnt_nxt  = '0;
            w_idx_nxt  = 2'd0;
            w_snap_nxt = w_inputs;
        end else if (w_col_wrap) begin
            w_cnt_nxt = '0;
            w_idx_nxt = r_idx + 2'd1;
            if (w_frame_wrap) begin
                w_snap_nxt = w_inputs;
            end
        end
    end

    // Column/row decode for the next cycle.
    always_comb begin
        w_drive_nxt = (w_cnt_nxt >= CW'(BLANK_CYCLES));
        w_sel_nxt   = 8'h00;
        case (w_idx_nxt)
            2'd0:    w_sel_nxt = w_snap_nxt[7:0];
            2'd1:    w_sel_nxt = w_snap_nxt[15:8];
            2'd2:    w_sel_nxt = w_snap_nxt[23:16];
            default: w_sel_nxt = w_snap_nxt[31:24];
        endcase
        w_rows_nxt = 8'hFF;
        w_cols_nxt = 4'hF;
        if (w_drive_nxt) begin
            w_rows_nxt = ~w_sel_nxt;
            w_cols_nxt = ~(4'b0001 << w_idx_nxt);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_idx       <= 2'd0;
            r_snap      <= w_inputs;
            led_rows    <= 8'hFF;
            led_columns <= 4'hF;
            frame_start <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_snap      <= w_snap_nxt;
            led_rows    <= w_rows_nxt;
            led_columns <= w_cols_nxt;
            frame_start <= w_frame_wrap;
        end
    end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Scoreboard bench for led_matrix_scanner with DRIVE_CYCLES=4, BLANK_CYCLES=2 (P=6, frame=24).
module tb_led_matrix_scanner;

    localparam int unsigned DRIVE = 4;
    localparam int unsigned BLANK = 2;
    localparam int unsigned P     = DRIVE + BLANK;
    localparam int unsigned FRAME = 4 * P;

    typedef struct packed {
        logic [7:0] rows;
        logic [3:0] cols;
        logic       fs;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] column_1, column_2, column_3, column_4;
    logic [7:0] led_rows;
    logic [3:0] led_columns;
    logic       frame_start;

    exp_t       q[$];
    int         n_chk  = 0;
    int         n_pass = 0;
    int         n_fail = 0;
    int         m_k    = 0;
    int         pulses = 0;
    logic [7:0] m_snap [4];
    logic [7:0] prev_rows = 8'hFF;
    logic [3:0] prev_cols = 4'hF;

    led_matrix_scanner #(.DRIVE_CYCLES(DRIVE), .BLANK_CYCLES(BLANK)) dut (
        .clk(clk), .reset(reset),
        .column_1(column_1), .column_2(column_2), .column_3(column_3), .column_4(column_4),
        .led_rows(led_rows), .led_columns(led_columns), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (k=%0d)", tag, obs, exp, m_k);
        end
    endtask

    // Spec timing: cnt = k mod P, idx = (k div P) mod 4, drive when cnt >= BLANK.
    function automatic exp_t model(input int k, input logic fs);
        exp_t e;
        int   cnt, idx;
        cnt = k % P;
        idx = (k / P) % 4;
        e.fs   = fs;
        e.rows = 8'hFF;
        e.cols = 4'hF;
        if (cnt >= BLANK) begin
            e.rows = ~m_snap[idx];
            e.cols = 4'hF;
            e.cols[idx] = 1'b0;
        end
        return e;
    endfunction

    // Push the expectation for the cycle after the next edge, clock, then pop and compare.
    task automatic step();
        exp_t e;
        logic fs;
        if (reset) begin
            m_k = 0;
            m_snap[0] = column_1; m_snap[1] = column_2;
            m_snap[2] = column_3; m_snap[3] = column_4;
            e = '{rows: 8'hFF, cols: 4'hF, fs: 1'b0};
        end else begin
            m_k++;
            fs = (m_k % FRAME == 0);
            if (fs) begin
                m_snap[0] = column_1; m_snap[1] = column_2;
                m_snap[2] = column_3; m_snap[3] = column_4;
            end
            e = model(m_k, fs);
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("rows", 32'(led_rows), 32'(e.rows));
        chk("cols", 32'(led_columns), 32'(e.cols));
        chk("frame_start", 32'(frame_start), 32'(e.fs));
        chk("col_onecold", 32'($countones(~led_columns) <= 1), 32'd1);
        if (prev_cols != 4'hF && led_columns != 4'hF)
            chk("row_stable", 32'(led_rows), 32'(prev_rows));
        if (frame_start) pulses++;
        prev_rows = led_rows;
        prev_cols = led_columns;
    endtask

    initial begin
        // Reset hold: A5 on all inputs, then the frame-0 image on the last reset cycle.
        reset = 1'b1;
        column_1 = 8'hA5; column_2 = 8'hA5; column_3 = 8'hA5; column_4 = 8'hA5;
        repeat (4) step();
        column_1 = 8'h01; column_2 = 8'h02; column_3 = 8'h04; column_4 = 8'h08;
        step();
        chk("rst_cols", 32'(led_columns), 32'hF);
        chk("rst_rows", 32'(led_rows), 32'hFF);
        reset = 1'b0;

        // Full frame scan, mid-frame change of column_1, second frame and pulse at k=48.
        while (m_k < 50) begin
            if (m_k == 9) column_1 = 8'hFF;
            step();
            case (m_k)
                1:  chk("k1_cols", 32'(led_columns), 32'hF);
                3:  begin chk("k3_cols", 32'(led_columns), 32'hE); chk("k3_rows", 32'(led_rows), 32'hFE); end
                7:  chk("k7_cols", 32'(led_columns), 32'hF);
                9:  begin chk("k9_cols", 32'(led_columns), 32'hD); chk("k9_rows", 32'(led_rows), 32'hFD); end
                15: begin chk("k15_cols", 32'(led_columns), 32'hB); chk("k15_rows", 32'(led_rows), 32'hFB); end
                21: begin chk("k21_cols", 32'(led_columns), 32'h7); chk("k21_rows", 32'(led_rows), 32'hF7); end
                24: chk("k24_fs", 32'(frame_start), 32'd1);
                26: begin chk("k26_cols", 32'(led_columns), 32'hE); chk("k26_rows", 32'(led_rows), 32'h00); end
                48: chk("k48_fs", 32'(frame_start), 32'd1);
                default: ;
            endcase
        end
        chk("pulse_count", 32'(pulses), 32'd2);

        // Reset mid-drive of column 2, then restart from column 1 without a pulse.
        reset = 1'b1; step(); reset = 1'b0;
        while (m_k < 9) step();
        reset = 1'b1; step(); reset = 1'b0;
        chk("midrst_cols", 32'(led_columns), 32'hF);
        chk("midrst_rows", 32'(led_rows), 32'hFF);
        pulses = 0;
        step(); step();
        chk("restart_cols", 32'(led_columns), 32'hE);
        while (m_k < 20) step();
        chk("no_pulse", 32'(pulses), 32'd0);

        // Random frames with random inputs and occasional reset pulses.
        for (int i = 0; i < 200 * int'(FRAME); i++) begin
            column_1 = 8'($urandom); column_2 = 8'($urandom);
            column_3 = 8'($urandom); column_4 = 8'($urandom);
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
